// File: rtl/rans_sym_fetch.sv
// AXI-lite read master that fetches a byte buffer from DDR and unpacks each
// 64-bit word little-endian into an 8-bit symbol stream for the rANS encoder.
module rans_sym_fetch #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int SYMBOL_WIDTH = 8,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [31:0]             len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [2:0]              m_arprot_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output logic [SYMBOL_WIDTH-1:0] sym_o,
    output logic                    sym_valid_o,
    input  logic                    sym_ready_i,
    output logic                    sym_last_o
);

    localparam int SPW    = DATA_WIDTH / SYMBOL_WIDTH;
    localparam int IDX_W  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(SPW - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [OCC_W-1:0]      DEPTH_C   = OCC_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_INC - ADDR_WIDTH'(1));
    localparam logic [31:0]           SPW_C     = 32'(SPW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             words_left_q, words_left_d;
    logic [31:0]             sym_left_q, sym_left_d;
    logic [CNT_W-1:0]        in_flight_q, in_flight_d;
    logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];

    logic                    in_run;
    logic                    in_flush;
    logic [OCC_W-1:0]        occupancy;
    logic                    ar_valid;
    logic                    ar_hs;
    logic                    r_ready;
    logic                    r_hs;
    logic                    push;
    logic                    r_err;
    logic                    sym_valid;
    logic                    sym_hs;
    logic                    last_sym;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   head_word;
    logic [SYMBOL_WIDTH-1:0] head_syms [SPW];
    logic [SYMBOL_WIDTH-1:0] sym_data;

    // A read is only issued when its beat is guaranteed a FIFO slot, so
    // rready can stay high for the whole transfer.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        in_flush  = (state_q == ST_FLUSH);
        occupancy = {1'b0, fifo_count_q} + {1'b0, in_flight_q};
        ar_valid  = in_run && (words_left_q != 32'd0) && (occupancy < DEPTH_C);
        ar_hs     = ar_valid && m_arready_i;
        r_ready   = in_run || in_flush;
        r_hs      = r_ready && m_rvalid_i;
        push      = r_hs && in_run && (m_rresp_i == 2'b00);
        r_err     = r_hs && in_run && (m_rresp_i != 2'b00);
        sym_valid = in_run && (fifo_count_q != '0);
        sym_hs    = sym_valid && sym_ready_i;
        last_sym  = (sym_left_q == 32'd1);
        pop       = sym_hs && ((idx_q == IDX_LAST) || last_sym);
    end

    always_comb begin
        head_word = mem_q[rd_ptr_q];
        for (int k = 0; k < SPW; k++) begin
            head_syms[k] = head_word[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        end
        sym_data = head_syms[idx_q];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        sym_left_d   = sym_left_q;
        in_flight_d  = in_flight_q;
        fifo_count_d = fifo_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        idx_d        = idx_q;
        err_d        = err_q;
        mem_d        = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d        = 1'b0;
                    addr_d       = base_addr_i & ADDR_MASK;
                    words_left_d = (len_i / SPW_C) + 32'((len_i % SPW_C) != 32'd0);
                    sym_left_d   = len_i;
                    in_flight_d  = '0;
                    fifo_count_d = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    idx_d        = '0;
                    state_d      = (len_i != 32'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (r_err) begin
                    err_d   = 1'b1;
                    state_d = ST_FLUSH;
                end else if (sym_hs && last_sym) begin
                    state_d = ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (in_flight_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ar_hs) begin
            addr_d       = addr_q + ADDR_INC;
            words_left_d = words_left_q - 32'd1;
        end

        if (ar_hs && !r_hs) begin
            in_flight_d = in_flight_q + CNT_ONE;
        end else if (!ar_hs && r_hs) begin
            in_flight_d = in_flight_q - CNT_ONE;
        end

        if (push) begin
            mem_d[wr_ptr_q] = m_rdata_i;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        // A short final word is popped at the last symbol, dropping its tail.
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            idx_d    = '0;
        end else if (sym_hs) begin
            idx_d = idx_q + IDX_ONE;
        end

        if (sym_hs) begin
            sym_left_d = sym_left_q - 32'd1;
        end

        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CNT_ONE;
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            sym_left_q   <= '0;
            in_flight_q  <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            sym_left_q   <= sym_left_d;
            in_flight_q  <= in_flight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            mem_q        <= mem_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;
    assign m_araddr_o  = addr_q;
    assign m_arprot_o  = 3'b000;
    assign m_arvalid_o = ar_valid;
    assign m_rready_o  = r_ready;
    assign sym_valid_o = sym_valid;
    assign sym_o       = sym_valid ? sym_data : '0;
    assign sym_last_o  = sym_valid && last_sym;

endmodule
